// File: rtl/pingpong_peak_scan_ctrl_if.sv
// Port B bus between the ping-pong RAM and its read-side scan controller.
// The master is the controller; the slave is the RAM/bank-manager side.
interface pingpong_peak_scan_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 7
);
    logic          readyb;
    logic [AW-1:0] addrb;
    logic          rd_en;
    logic [DW-1:0] doutb;
    logic          finishb;

    modport master (
        input  readyb,
        input  doutb,
        output addrb,
        output rd_en,
        output finishb
    );

    modport slave (
        output readyb,
        output doutb,
        input  addrb,
        input  rd_en,
        input  finishb
    );
endinterface

// File: rtl/pingpong_peak_scan_ctrl.sv
// Scans one ping-pong bank through port B, finds the peak value, its first address
// and later tied addresses, then releases the bank and publishes registered results.
module pingpong_peak_scan_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2,
    parameter int TIE_N  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pingpong_peak_scan_ctrl_if.master    bus,
    output logic                         busy,
    output logic                         done,
    output logic [DW-1:0]                max_data,
    output logic [AW-1:0]                max_addr,
    output logic [$clog2(TIE_N+1)-1:0]   tie_cnt,
    output logic                         tie_ovf,
    input  logic [$clog2(TIE_N)-1:0]     tie_sel,
    output logic [AW-1:0]                tie_addr
);
    localparam int CW = $clog2(TIE_N+1);
    localparam int SW = $clog2(TIE_N);
    localparam int LW = $clog2(RD_LAT+1);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH-1);
    localparam logic [CW-1:0] TIE_FULL   = CW'(TIE_N);
    localparam logic [LW-1:0] LAST_DRAIN = LW'(RD_LAT-1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, RELEASE, DONE} state_t;
    state_t state, state_next;

    logic          readyb_q;
    logic          start;
    logic          rd_en_c;
    logic          finish_c;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] drain_q;
    logic          tag_v [RD_LAT];
    logic [AW-1:0] tag_a [RD_LAT];
    logic          smp_valid;
    logic [AW-1:0] smp_addr;

    logic          first_q;
    logic [DW-1:0] wmax;
    logic [AW-1:0] waddr;
    logic [CW-1:0] wcnt;
    logic          wovf;
    logic [AW-1:0] tie_w [TIE_N];
    logic [AW-1:0] tie_o [TIE_N];

    assign start       = bus.readyb & ~readyb_q;
    assign smp_valid   = tag_v[RD_LAT-1];
    assign smp_addr    = tag_a[RD_LAT-1];
    assign bus.addrb   = addr_q;
    assign bus.rd_en   = rd_en_c;
    assign bus.finishb = finish_c;
    assign tie_addr    = tie_o[tie_sel];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_en_c    = 1'b0;
        finish_c   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = READ;
            end
            READ: begin
                rd_en_c = 1'b1;
                if (addr_q == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) state_next = RELEASE;
            end
            RELEASE: begin
                finish_c   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Each issued address travels with its own valid bit so the compare never derives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            readyb_q <= 1'b0;
            addr_q   <= '0;
            drain_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_v[i] <= 1'b0;
        end else begin
            readyb_q <= bus.readyb;
            if (state == READ) addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            drain_q  <= (state == DRAIN) ? drain_q + 1'b1 : '0;
            tag_v[0] <= rd_en_c;
            tag_a[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
            wmax    <= '0;
            waddr   <= '0;
            wcnt    <= '0;
            wovf    <= 1'b0;
        end else if (state == IDLE && start) begin
            first_q <= 1'b1;
            wmax    <= '0;
            waddr   <= '0;
            wcnt    <= '0;
            wovf    <= 1'b0;
        end else if (smp_valid) begin
            if (first_q || bus.doutb > wmax) begin
                first_q <= 1'b0;
                wmax    <= bus.doutb;
                waddr   <= smp_addr;
                wcnt    <= '0;
                wovf    <= 1'b0;
            end else if (bus.doutb == wmax) begin
                if (wcnt < TIE_FULL) begin
                    tie_w[wcnt[SW-1:0]] <= smp_addr;
                    wcnt                <= wcnt + 1'b1;
                end else begin
                    wovf <= 1'b1;
                end
            end
        end
    end

    // Published on the RELEASE->DONE edge so results are already stable while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_data <= '0;
            max_addr <= '0;
            tie_cnt  <= '0;
            tie_ovf  <= 1'b0;
        end else if (state == RELEASE) begin
            max_data <= wmax;
            max_addr <= waddr;
            tie_cnt  <= wcnt;
            tie_ovf  <= wovf;
            tie_o    <= tie_w;
        end
    end
endmodule
